// File: rtl/universal_shift_engine.sv
// Multi-mode shift register that runs `count` shift steps of up to K bits each
// (logical, arithmetic and rotate), with parallel load and a one-cycle done pulse.
module universal_shift_engine #(
  parameter  int N  = 25,
  parameter  int K  = 4,
  localparam int SW = $clog2(K + 1),
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [N-1:0]  in,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [SW-1:0] step,
  input  logic [CW-1:0] count,
  input  logic [K-1:0]  fill,
  output logic [N-1:0]  out,
  output logic [K-1:0]  shift_out,
  output logic          busy,
  output logic          done,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [2:0] M_LSL = 3'b000;
  localparam logic [2:0] M_LSR = 3'b001;
  localparam logic [2:0] M_ASR = 3'b010;
  localparam logic [2:0] M_ROL = 3'b011;
  localparam logic [2:0] M_ROR = 3'b100;
  localparam logic [SW-1:0] K_S = SW'(K);

  state_t        state_q, state_d;
  logic [N-1:0]  out_q, out_d;
  logic [K-1:0]  so_q, so_d;
  logic [2:0]    mode_q, mode_d;
  logic [SW-1:0] step_q, step_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  int            s;
  logic [N-1:0]  smask;
  logic [N-1:0]  fill_m;
  logic [N-1:0]  sh_out;
  logic [K-1:0]  sh_so;

  // One shift by the captured effective step; s is always in 1..K, so N-s never reaches N.
  always_comb begin
    s      = int'(step_q);
    smask  = {N{1'b1}} >> (N - s);
    fill_m = {{(N-K){1'b0}}, fill} & smask;
    sh_out = out_q;
    sh_so  = '0;
    case (mode_q)
      M_LSL: begin
        sh_out = (out_q << s) | fill_m;
        sh_so  = K'(out_q >> (N - s));
      end
      M_LSR: begin
        sh_out = (out_q >> s) | (fill_m << (N - s));
        sh_so  = K'(out_q & smask);
      end
      M_ASR: begin
        sh_out = $signed(out_q) >>> s;
        sh_so  = K'(out_q & smask);
      end
      M_ROL: begin
        sh_out = (out_q << s) | (out_q >> (N - s));
        sh_so  = K'(out_q >> (N - s));
      end
      M_ROR: begin
        sh_out = (out_q >> s) | (out_q << (N - s));
        sh_so  = K'(out_q & smask);
      end
      default: begin
        sh_out = out_q;
        sh_so  = '0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    so_d    = so_q;
    mode_d  = mode_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    if (ld) begin
      out_d   = in;
      so_d    = '0;
      cnt_d   = '0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_d  = mode;
            step_d  = (step == '0) ? SW'(1) : ((step > K_S) ? K_S : step);
            cnt_d   = count;
            state_d = (count != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          out_d = sh_out;
          so_d  = sh_so;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      so_q    <= '0;
      mode_q  <= '0;
      step_q  <= SW'(1);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      so_q    <= so_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out       = out_q;
  assign shift_out = so_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: doc/universal_shift_engine.md
UNIVERSAL_SHIFT_ENGINE -- requirements
Module: universal_shift_engine

Interface
REQ-001 SHALL have parameter N, default 25: register width in bits; legal range N >= 2.
REQ-002 SHALL have parameter K, default 4: maximum bits moved per shift step; legal range 1 <= K <= N-1.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port ld, input, 1 bit: parallel load request.
REQ-006 SHALL have port in, input, N bits: parallel load data.
REQ-007 SHALL have port start, input, 1 bit: begin a shift run.
REQ-008 SHALL have port mode, input, 3 bits: 000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR, 101-111 reserved.
REQ-009 SHALL have port step, input, clog2(K+1) bits: bits moved per shift.
REQ-010 SHALL have port count, input, clog2(N+1) bits: number of shift steps in the run.
REQ-011 SHALL have port fill, input, K bits: serial fill bits for LSL and LSR.
REQ-012 SHALL have port out, output, N bits: register contents.
REQ-013 SHALL have port shift_out, output, K bits: bits that exited on the last shift, zero-extended.
REQ-014 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a run.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-017 SHALL, in IDLE on start=1 and ld=0, capture mode, step and count, and go to RUN if count != 0, otherwise to DONE.
REQ-018 SHALL clamp the captured step: a value of 0 becomes 1, and a value greater than K becomes K (s = effective step).
REQ-019 SHALL, in RUN on each edge, perform one shift, decrement the remaining count, and go to DONE when the remaining count reaches 0.
REQ-020 SHALL produce done and busy with this timing: start at edge E0, shifts at edges E1..Ecount, done=1 during the cycle after Ecount, and IDLE at the next edge.
REQ-021 SHALL apply the mode-dependent shift each step:
- LSL: out <= {out[N-1-s:0], fill[s-1:0]}.
- LSR: out <= {fill[s-1:0], out[N-1:s]}.
- ASR: vacated MSBs take the copy of out[N-1].
- ROL and ROR: rotate by s.
- Reserved modes: out holds, but the count still decrements.
REQ-022 SHALL set shift_out on each shift to the s exiting bits, right-aligned and zero-extended: out[N-1:N-s] for LSL and ROL, out[s-1:0] for LSR, ASR and ROR. Reserved modes SHALL load 0. shift_out SHALL hold between shifts.
REQ-023 SHALL make ld highest priority in every state: out <= in, shift_out <= 0, FSM to IDLE. A ld during RUN aborts the run with no done pulse.
REQ-024 SHALL ignore start while in RUN or DONE, and ignore start when ld is asserted in the same cycle.
REQ-025 SHALL ignore mode, step, count and fill changes during RUN; only the captured values and the live fill input apply, with fill sampled every step.
REQ-026 SHALL keep out unchanged in IDLE and DONE when ld=0.

Reset
REQ-027 SHALL, when rst=1 (immediately, independent of clk), set out=0, shift_out=0, busy=0, done=0, FSM=IDLE and the remaining count to 0, including in the middle of a run.
REQ-028 SHALL, after rst deasserts, respond to the first clock edge normally, with no extra wait cycles.

Verification (N=8, K=4)
REQ-029 SHALL pass: ld 8'hA5, then start LSL step=1 count=3 fill=4'h1 -> out 4B, 97, 2F at E1..E3; done=1 one cycle; busy=1 for exactly 3 cycles.
REQ-030 SHALL pass: ld 8'h90, then ASR step=3 count=1 -> out=8'hF2, shift_out=4'h0.
REQ-031 SHALL pass: ld 8'h3C, then ROL step=4 count=2 -> out C3 then 3C; shift_out 4'h3 then 4'hC.
REQ-032 SHALL pass: start with count=0 -> busy stays 0, done pulses the cycle after start, out unchanged; step=0 with count=1 LSL on 8'h01, fill=0 -> out=8'h02.
REQ-033 SHALL pass: ld 8'h55 asserted at E2 of a count=5 run -> out=8'h55, busy=0, no done pulse.
REQ-034 SHALL pass: rst pulsed between clock edges mid-run -> all outputs 0 without waiting for an edge; the next start runs correctly.
